// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder sequencer driving an external 1-bit full-adder cell, LSB first.
// Latency WIDTH+1 cycles start-to-done; start is ignored while busy and is never queued.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_run;
    logic [WIDTH-1:0] w_s_next;

    assign w_run    = (r_state == RUN);
    assign w_s_next = {fa_s, r_s_sh[WIDTH-1:1]};

    // Cell inputs are gated so the cell sees all-zero outside RUN.
    assign fa_a   = w_run & r_a_sh[0];
    assign fa_b   = w_run & r_b_sh[0];
    assign fa_cin = w_run & r_carry;

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= op_a;
                        r_b_sh  <= op_b;
                        r_carry <= cin;
                        r_s_sh  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_s_sh  <= w_s_next;
                    r_carry <= fa_cout;
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_sum   <= w_s_next;
                        r_cout  <= fa_cout;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Randomized and directed bench: acceptance/latency model plus arithmetic reference feed a scoreboard.
module tb_serial_add_seq;

    localparam int W  = 8;
    localparam int W2 = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic         fa_a, fa_b, fa_cin, fa_s, fa_cout;
    int           fault = 0;

    logic          start2 = 1'b0;
    logic [W2-1:0] op_a2 = '0;
    logic [W2-1:0] op_b2 = '0;
    logic          cin2 = 1'b0;
    logic          busy2, done2, cout2;
    logic [W2-1:0] sum2;
    logic          fa_a2, fa_b2, fa_cin2, fa_s2, fa_cout2;

    always #5 clk = ~clk;

    // Behavioural full-adder cells; the main one can be forced into stuck-at faults.
    assign fa_s    = (fault == 1) ? 1'b0 : (fa_a ^ fa_b ^ fa_cin);
    assign fa_cout = (fault == 2) ? 1'b1 : ((fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin));
    assign fa_s2    = fa_a2 ^ fa_b2 ^ fa_cin2;
    assign fa_cout2 = (fa_a2 & fa_b2) | (fa_a2 & fa_cin2) | (fa_b2 & fa_cin2);

    serial_add_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout)
    );

    serial_add_seq #(.WIDTH(W2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op_a(op_a2), .op_b(op_b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
        .fa_a(fa_a2), .fa_b(fa_b2), .fa_cin(fa_cin2), .fa_s(fa_s2), .fa_cout(fa_cout2)
    );

    typedef struct {
        logic [W:0] res;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   free_at = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference result from plain arithmetic, including the two fault signatures.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c, input int f);
        logic [W:0]   good;
        logic [W-1:0] cmask;
        good  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        cmask = {{(W-1){1'b1}}, c};
        if (f == 1) return {good[W], {W{1'b0}}};
        if (f == 2) return {1'b1, a ^ b ^ cmask};
        return good;
    endfunction

    // Model: an op is accepted when start is seen and the previous one has fully retired.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            free_at = cyc + 1;
        end else if (start && cyc >= free_at) begin
            exp_q.push_back('{res: ref_add(op_a, op_b, cin, fault), due: cyc + W + 1});
            free_at = cyc + W + 2;
        end
        cyc = cyc + 1;
    end

    // Monitor: compare every done pulse against the scoreboard head; busy against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy), 32'(cyc < free_at));
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                chk("done_timeout", 32'(done), 32'd1);
                void'(exp_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_latency", 32'(cyc), 32'(e.due));
                    chk("sum", 32'(sum), 32'(e.res[W-1:0]));
                    chk("cout", 32'(cout), 32'(e.res[W]));
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        start = 1'b1; op_a = a; op_b = b; cin = c;
        @(posedge clk); #1;
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
        repeat (W + 1) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(8'h05, 8'h03, 1'b0);
        chk("dir_05_03", {23'd0, cout, sum}, 32'h008);
        issue(8'hFF, 8'h01, 1'b0);
        chk("dir_ff_01", {23'd0, cout, sum}, 32'h100);
        issue(8'hFF, 8'hFF, 1'b1);
        chk("dir_ff_ff_1", {23'd0, cout, sum}, 32'h1FF);

        // start held high, operands changing every cycle
        for (int i = 0; i < 30; i++) begin
            start = 1'b1; op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;

        // random start blips, many landing while busy
        for (int i = 0; i < 300; i++) begin
            start = ($urandom_range(0, 3) == 0);
            op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;

        // reset in the 4th RUN cycle aborts and clears the held result
        issue(8'h05, 8'h03, 1'b0);
        start = 1'b1; op_a = 8'h10; op_b = 8'h20; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        issue(8'h10, 8'h20, 1'b0);
        chk("after_abort", {23'd0, cout, sum}, 32'h030);

        fault = 1;
        issue(8'h5A, 8'h21, 1'b0);
        chk("stuck_s0", {23'd0, cout, sum}, 32'h000);
        fault = 2;
        issue(8'h00, 8'h00, 1'b0);
        chk("stuck_cout1", {23'd0, cout, sum}, 32'h1FE);
        fault = 0;
        @(posedge clk); #1;

        // narrow instance
        start2 = 1'b1; op_a2 = 2'h3; op_b2 = 2'h3; cin2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0; op_a2 = 2'h0; op_b2 = 2'h0; cin2 = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done2) break;
        end
        chk("w2_latency", 32'(n), 32'(W2 + 1));
        chk("w2_sum", 32'(sum2), 32'h3);
        chk("w2_cout", 32'(cout2), 32'h1);
        @(negedge clk);
        chk("w2_done_pulse", 32'(done2), 32'd0);

        repeat (W + 4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
